// File: rtl/fcc_pkg.sv
// Shared constants and helpers for the credit-based flow-control bank.
package fcc_pkg;

  // Router port indices, north first.
  localparam int P_NORTH = 0;
  localparam int P_SOUTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_WEST  = 3;
  localparam int P_LOCAL = 4;

  // Default geometry of the bank.
  localparam int DEF_NUM_PORTS   = 5;
  localparam int DEF_NUM_VC      = 2;
  localparam int DEF_MAX_CREDITS = 4;

  // Flat channel index for a (port, vc) pair; channels of one port are adjacent.
  function automatic int chan_idx(input int port, input int vc, input int num_vc = DEF_NUM_VC);
    return port * num_vc + vc;
  endfunction

endpackage

// File: rtl/fcc_credit_ctr.sv
// Single-channel saturating credit counter with sticky overflow/underflow flags.
module fcc_credit_ctr
  import fcc_pkg::*;
#(
  parameter int   MAX_CREDITS = DEF_MAX_CREDITS,
  parameter int   LOW_THRESH  = 1,
  localparam int  CNT_W       = $clog2(MAX_CREDITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_i,
  input  logic             incr_i,
  input  logic             decr_i,
  input  logic             err_clr_i,
  output logic             en_o,
  output logic             low_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_ovf_o,
  output logic             err_unf_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CREDITS);
  localparam logic [CNT_W-1:0] LOW_CNT = CNT_W'(LOW_THRESH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Next-state: re-init dominates, then clear, then count/error update (set beats clear).
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (init_i) begin
      cnt_d = MAX_CNT;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      if (err_clr_i) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      unique case ({incr_i, decr_i})
        2'b10: begin
          if (cnt_q == MAX_CNT) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q == '0) unf_d = 1'b1;
          else             cnt_d = cnt_q - CNT_W'(1);
        end
        default: ;  // idle, or a send and a return cancelling out
      endcase
    end
  end

  // State registers; reset restores a full credit pool immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge value of its inputs.
    if (rst) begin
      cnt_q <= MAX_CNT;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Outputs decode registered state only.
  assign cnt_o     = cnt_q;
  assign en_o      = (cnt_q != '0);
  assign low_o     = (cnt_q <= LOW_CNT);
  assign err_ovf_o = ovf_q;
  assign err_unf_o = unf_q;

endmodule

// File: rtl/fcc_credit_bank.sv
// Bank of per-(port, VC) credit counters feeding the router output links.
module fcc_credit_bank
  import fcc_pkg::*;
#(
  parameter int  NUM_PORTS   = DEF_NUM_PORTS,
  parameter int  NUM_VC      = DEF_NUM_VC,
  parameter int  MAX_CREDITS = DEF_MAX_CREDITS,
  parameter int  LOW_THRESH  = 1,
  localparam int CNT_W       = $clog2(MAX_CREDITS + 1),
  localparam int NUM_CH      = NUM_PORTS * NUM_VC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_i,
  input  logic [NUM_CH-1:0]       decr_i,
  input  logic [NUM_CH-1:0]       incr_i,
  input  logic                    err_clr_i,
  output logic [NUM_CH-1:0]       credit_en_o,
  output logic [NUM_CH-1:0]       credit_low_o,
  output logic [NUM_CH*CNT_W-1:0] credit_cnt_o,
  output logic [NUM_CH-1:0]       err_ovf_o,
  output logic [NUM_CH-1:0]       err_unf_o
);

  // One independent counter per channel; fields packed with channel 0 in the LSBs.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
      localparam int CH = chan_idx(p, v, NUM_VC);

      fcc_credit_ctr #(
        .MAX_CREDITS (MAX_CREDITS),
        .LOW_THRESH  (LOW_THRESH)
      ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .init_i    (init_i),
        .incr_i    (incr_i[CH]),
        .decr_i    (decr_i[CH]),
        .err_clr_i (err_clr_i),
        .en_o      (credit_en_o[CH]),
        .low_o     (credit_low_o[CH]),
        .cnt_o     (credit_cnt_o[CH*CNT_W +: CNT_W]),
        .err_ovf_o (err_ovf_o[CH]),
        .err_unf_o (err_unf_o[CH])
      );
    end
  end

endmodule

// File: doc/fcc_credit_bank.md
Name: fcc_credit_bank

Overview:
- Parametrised credit-based flow-control counter bank for the NoC router.
- Tracks downstream buffer credits per (port, virtual channel).
- Decrements a counter on each flit sent and increments it on each credit returned.
- Asserts a per-channel send enable while credits remain. Sits between the router's switch allocator and the output links.
- Generalises the fixed 5-port, single-counter FCC to N ports × V VCs with saturating counters, a low-water flag, sticky error detection and a synchronous re-initialise.

Parameters:
- NUM_PORTS, 5, router ports (N,S,E,W,L order; index 0 = north).
- NUM_VC, 2, virtual channels per port.
- MAX_CREDITS, 4, downstream buffer depth per VC; also the counter reset value.
- LOW_THRESH, 1, credit_low_o asserts when count <= LOW_THRESH; legal range 0..MAX_CREDITS-1.
- CNT_W, $clog2(MAX_CREDITS+1), counter width (derived; do not override).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- init_i, in, 1, synchronous re-initialise of all counters and errors.
- decr_i, in, NUM_PORTS*NUM_VC, flit sent on channel (consumes one credit). Channel index = port*NUM_VC+vc.
- incr_i, in, NUM_PORTS*NUM_VC, credit returned from downstream.
- err_clr_i, in, 1, clears sticky error bits.
- credit_en_o, out, NUM_PORTS*NUM_VC, channel has >=1 credit.
- credit_low_o, out, NUM_PORTS*NUM_VC, channel count <= LOW_THRESH.
- credit_cnt_o, out, NUM_PORTS*NUM_VC*CNT_W, current count per channel, packed.
- err_ovf_o, out, NUM_PORTS*NUM_VC, sticky: incr on a full counter.
- err_unf_o, out, NUM_PORTS*NUM_VC, sticky: decr on an empty counter.

Behaviour:
- Reset (rst high, asynchronous):
  - all counters = MAX_CREDITS; credit_en_o all 1.
  - credit_low_o all 0 (LOW_THRESH < MAX_CREDITS).
  - err_ovf_o and err_unf_o all 0.
  - credit_cnt_o = MAX_CREDITS per field.
- Per channel, evaluated each rising edge of clk:
  - init_i=1: count <= MAX_CREDITS, both error bits cleared; incr/decr ignored that cycle.
  - incr=1 and decr=1: count unchanged; no error, even at 0 or at MAX.
  - incr only, count < MAX: count+1.
  - incr only, count == MAX: count held (saturate); err_ovf set.
  - decr only, count > 0: count-1.
  - decr only, count == 0: count held at 0; err_unf set.
  - neither: hold.
- Error bits:
  - err_clr_i=1 clears all error bits that cycle.
  - If a new error event occurs in the same cycle as err_clr_i, set wins.
- Output timing:
  - All outputs are functions of registered state only; no combinational path from inputs to outputs.
  - Latency input-edge -> output change = 1 cycle.
  - credit_en_o = (count != 0); credit_low_o = (count <= LOW_THRESH).
- Upstream contract: decr_i asserted only when credit_en_o is high that cycle. Any violation is flagged by err_unf, never wraps.
- Channels are fully independent; any combination of channels may incr/decr in the same cycle.
- Reset asserted mid-operation: counters return to MAX immediately, regardless of clock; in-flight credits are discarded.

Decomposition:
- Package fcc_pkg holds:
  - port index constants P_NORTH=0, P_SOUTH=1, P_EAST=2, P_WEST=3, P_LOCAL=4;
  - the default NUM_PORTS / NUM_VC / MAX_CREDITS values;
  - a chan_idx(port, vc) function.
- One sub-module, fcc_credit_ctr: a single-channel saturating counter with error flags, params MAX_CREDITS and LOW_THRESH.
- The top generates NUM_PORTS*NUM_VC instances and packs their outputs.

Test Plan:
- Reset -> every credit_cnt field = 4, credit_en all 1, credit_low all 0, errors 0.
- Channel (E,vc1) decr 3 consecutive cycles -> counts 3,2,1 visible one cycle after each edge; credit_low asserts when count = 1; a 4th decr gives 0 and credit_en low; other channels stay at 4.
- Channel at 0 gets incr+decr same cycle -> stays 0, no err_unf. A lone decr -> stays 0, err_unf set and sticky. err_clr_i -> cleared next cycle.
- Channel at 4 gets lone incr -> stays 4, err_ovf set. incr in the same cycle as err_clr_i -> err_ovf remains set.
- All 10 channels decr simultaneously for 2 cycles, then init_i with incr asserted -> all counts = 4 next cycle, errors 0.
- rst pulsed asynchronously between clock edges while counts are mixed -> outputs return to reset values before the next edge.
